// File: rtl/if_redirect_stage_pkg.sv
// if_redirect_stage_pkg
//   Shared constants and the redirect-kind encoding for the fetch redirect stage.
//   The redirect kinds are ordered numerically by priority, so a plain magnitude
//   compare of two kinds tells which one wins.
package if_redirect_stage_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IM_BYTES = 32'h0000_1000;

    typedef enum logic [1:0] {
        REDIR_NONE = 2'd0,
        REDIR_BR   = 2'd1,
        REDIR_ERET = 2'd2,
        REDIR_EXC  = 2'd3
    } redir_kind_e;

endpackage

// File: rtl/if_redirect_stage_if.sv
// if_redirect_stage_if
//   Groups the fetch/decode-side signals of the redirect stage.
//   master: pipeline side (drives stall, fetch data and redirect requests).
//   slave : the redirect stage (drives npc_f and the IF/ID register outputs).
interface if_redirect_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             stall;
    logic [WIDTH-1:0] pc_f;
    logic [31:0]      instr_f;
    logic             br_req;
    logic [WIDTH-1:0] br_target;
    logic             is_jb_d;
    logic             eret_req;
    logic [WIDTH-1:0] epc;
    logic             exc_req;
    logic [WIDTH-1:0] npc_f;
    logic [31:0]      instr_d;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc8_d;
    logic             valid_d;
    logic             adel_d;
    logic             bd_d;

    modport master (
        output stall, pc_f, instr_f, br_req, br_target, is_jb_d, eret_req, epc, exc_req,
        input  npc_f, instr_d, pc_d, pc8_d, valid_d, adel_d, bd_d
    );

    modport slave (
        input  stall, pc_f, instr_f, br_req, br_target, is_jb_d, eret_req, epc, exc_req,
        output npc_f, instr_d, pc_d, pc8_d, valid_d, adel_d, bd_d
    );
endinterface

// File: rtl/if_redirect_stage_redirect_pend.sv
// if_redirect_stage_redirect_pend
//   Priority arbiter plus pending-redirect FSM. Requests seen while stalled are
//   captured (a later, strictly higher-priority request overwrites) and applied on
//   the first unstalled cycle; a same-cycle request of equal or higher priority
//   beats the pending one.
//   Ports: clk, reset (sync, active-high), stall, br_req/br_target, eret_req/epc,
//   exc_req in; apply (redirect taken this cycle), apply_kind, apply_tgt out
//   (combinational, only meaningful with stall=0).
module if_redirect_stage_redirect_pend
    import if_redirect_stage_pkg::*;
#(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(if_redirect_stage_pkg::EXC_VEC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_req,
    input  logic [WIDTH-1:0] br_target,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc,
    input  logic             exc_req,
    output logic             apply,
    output redir_kind_e      apply_kind,
    output logic [WIDTH-1:0] apply_tgt
);

    typedef enum logic {StIdle, StPend} pend_state_e;

    pend_state_e      state_q;
    redir_kind_e      pend_kind_q;
    logic [WIDTH-1:0] pend_tgt_q;

    redir_kind_e      cur_kind;
    logic [WIDTH-1:0] cur_tgt;

    always_comb begin
        cur_kind = REDIR_NONE;
        cur_tgt  = '0;
        if (exc_req) begin
            cur_kind = REDIR_EXC;
            cur_tgt  = EXC_VEC;
        end else if (eret_req) begin
            cur_kind = REDIR_ERET;
            cur_tgt  = epc;
        end else if (br_req) begin
            cur_kind = REDIR_BR;
            cur_tgt  = br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            pend_kind_q <= REDIR_NONE;
            pend_tgt_q  <= '0;
        end else if (stall) begin
            if ((cur_kind != REDIR_NONE) && ((state_q == StIdle) || (cur_kind > pend_kind_q))) begin
                state_q     <= StPend;
                pend_kind_q <= cur_kind;
                pend_tgt_q  <= cur_tgt;
            end
        end else begin
            // Any pending redirect is consumed on the first unstalled cycle.
            state_q     <= StIdle;
            pend_kind_q <= REDIR_NONE;
        end
    end

    always_comb begin
        apply      = 1'b0;
        apply_kind = REDIR_NONE;
        apply_tgt  = '0;
        if (!stall) begin
            if ((state_q == StPend) && (cur_kind < pend_kind_q)) begin
                apply      = 1'b1;
                apply_kind = pend_kind_q;
                apply_tgt  = pend_tgt_q;
            end else if (cur_kind != REDIR_NONE) begin
                apply      = 1'b1;
                apply_kind = cur_kind;
                apply_tgt  = cur_tgt;
            end
        end
    end

endmodule

// File: rtl/if_redirect_stage.sv
// if_redirect_stage
//   Computes the next PC (sequential, branch/jump, ERET or exception target) for
//   the PC register and holds the IF/ID pipeline register.
//   Ports: clk, reset (sync, active-high), bus (if_redirect_stage_if.slave):
//   stall, pc_f, instr_f, br_req, br_target, is_jb_d, eret_req, epc, exc_req in;
//   npc_f (combinational), instr_d, pc_d, pc8_d, valid_d, adel_d, bd_d out.
//   Build option DELAY_SLOT_EN: when defined, a branch redirect keeps the
//   delay-slot instruction (bd_d marks it); otherwise branches also squash the
//   instruction in F and bd_d is always 0.
module if_redirect_stage
    import if_redirect_stage_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(if_redirect_stage_pkg::RESET_PC),
    parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(if_redirect_stage_pkg::EXC_VEC),
    parameter logic [WIDTH-1:0] IM_BASE  = WIDTH'(if_redirect_stage_pkg::IM_BASE),
    parameter logic [WIDTH-1:0] IM_BYTES = WIDTH'(if_redirect_stage_pkg::IM_BYTES)
) (
    input logic              clk,
    input logic              reset,
    if_redirect_stage_if.slave bus
);

    localparam logic [WIDTH-1:0] IM_END = IM_BASE + IM_BYTES;

    logic             apply;
    redir_kind_e      apply_kind;
    logic [WIDTH-1:0] apply_tgt;

    logic [31:0]      instr_q;
    logic [WIDTH-1:0] pc_q;
    logic             valid_q;
    logic             adel_q;
    logic             bd_q;
    logic             bd_next;
    logic             flush;
    logic             fetch_adel;
    logic [WIDTH-1:0] pc_plus4;

    if_redirect_stage_redirect_pend #(
        .WIDTH   (WIDTH),
        .EXC_VEC (EXC_VEC)
    ) u_redirect_pend (
        .clk        (clk),
        .reset      (reset),
        .stall      (bus.stall),
        .br_req     (bus.br_req),
        .br_target  (bus.br_target),
        .eret_req   (bus.eret_req),
        .epc        (bus.epc),
        .exc_req    (bus.exc_req),
        .apply      (apply),
        .apply_kind (apply_kind),
        .apply_tgt  (apply_tgt)
    );

    assign pc_plus4   = bus.pc_f + WIDTH'(4);
    assign bus.npc_f  = apply ? apply_tgt : pc_plus4;
    assign fetch_adel = (bus.pc_f[1:0] != 2'b00) || (bus.pc_f < IM_BASE) ||
                        (bus.pc_f >= IM_END);

`ifdef DELAY_SLOT_EN
    // Branches keep the delay-slot instruction; only exc/eret squash F.
    assign flush   = apply && ((apply_kind == REDIR_EXC) || (apply_kind == REDIR_ERET));
    assign bd_next = bus.is_jb_d & valid_q;
`else
    // apply implies a real redirect kind, so every applied redirect squashes F.
    assign flush   = apply;
    assign bd_next = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            adel_q  <= 1'b0;
            bd_q    <= 1'b0;
        end else if (!bus.stall) begin
            // pc_d is loaded even on a flush so it can serve as EPC.
            pc_q <= bus.pc_f;
            if (flush) begin
                instr_q <= '0;
                valid_q <= 1'b0;
                adel_q  <= 1'b0;
                bd_q    <= 1'b0;
            end else begin
                instr_q <= fetch_adel ? 32'h0 : bus.instr_f;
                valid_q <= 1'b1;
                adel_q  <= fetch_adel;
                bd_q    <= bd_next;
            end
        end
    end

    assign bus.instr_d = instr_q;
    assign bus.pc_d    = pc_q;
    assign bus.pc8_d   = pc_q + WIDTH'(8);
    assign bus.valid_d = valid_q;
    assign bus.adel_d  = adel_q;
    assign bus.bd_d    = bd_q;

endmodule

// File: tb/tb_if_redirect_stage.sv
// tb_if_redirect_stage
//   Directed vectors with hand-computed expectations for if_redirect_stage.
module tb_if_redirect_stage;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    if_redirect_stage_if #(.WIDTH(32)) bus ();

    if_redirect_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_req();
        bus.br_req   = 1'b0;
        bus.eret_req = 1'b0;
        bus.exc_req  = 1'b0;
        bus.is_jb_d  = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset         = 1'b1;
        bus.stall     = 1'b0;
        bus.pc_f      = 32'h3008;
        bus.instr_f   = 32'h2408_0001;
        bus.br_target = 32'h0;
        bus.epc       = 32'h0;
        clear_req();

        // Reset state
        tick();
        settle();
        check("rst_pc_d", bus.pc_d, 32'h3000);
        check("rst_valid", {31'b0, bus.valid_d}, 32'h0);
        check("rst_instr", bus.instr_d, 32'h0);
        check("rst_adel", {31'b0, bus.adel_d}, 32'h0);
        check("rst_bd", {31'b0, bus.bd_d}, 32'h0);
        check("rst_npc", bus.npc_f, 32'h300C);
        check("rst_pc8", bus.pc8_d, 32'h3008);

        // First fetch after release
        reset = 1'b0;
        tick();
        check("ld_instr", bus.instr_d, 32'h2408_0001);
        check("ld_valid", {31'b0, bus.valid_d}, 32'h1);
        check("ld_pc_d", bus.pc_d, 32'h3008);
        check("ld_pc8", bus.pc8_d, 32'h3010);

        // Unstalled branch
        bus.pc_f      = 32'h3010;
        bus.instr_f   = 32'h1111_1111;
        bus.br_req    = 1'b1;
        bus.br_target = 32'h3100;
        bus.is_jb_d   = 1'b1;
        settle();
        check("br_npc", bus.npc_f, 32'h3100);
        tick();
        clear_req();
        check("br_pc_d", bus.pc_d, 32'h3010);
`ifdef DELAY_SLOT_EN
        check("br_valid", {31'b0, bus.valid_d}, 32'h1);
        check("br_instr", bus.instr_d, 32'h1111_1111);
        check("br_bd", {31'b0, bus.bd_d}, 32'h1);
`else
        check("br_valid", {31'b0, bus.valid_d}, 32'h0);
        check("br_instr", bus.instr_d, 32'h0);
        check("br_bd", {31'b0, bus.bd_d}, 32'h0);
`endif

        // Branch requested during a 3-cycle stall, request dropped after cycle 1
        bus.pc_f    = 32'h3100;
        bus.instr_f = 32'h2222_2222;
        tick();
        check("pre_stall_instr", bus.instr_d, 32'h2222_2222);
        bus.stall     = 1'b1;
        bus.br_req    = 1'b1;
        bus.br_target = 32'h3200;
        bus.pc_f      = 32'h3104;
        bus.instr_f   = 32'h3333_3333;
        settle();
        check("stall_npc_seq", bus.npc_f, 32'h3108);
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.br_req = 1'b0;
            check("stall_hold_instr", bus.instr_d, 32'h2222_2222);
            check("stall_hold_pc", bus.pc_d, 32'h3100);
            check("stall_hold_valid", {31'b0, bus.valid_d}, 32'h1);
        end
        bus.stall = 1'b0;
        settle();
        check("pend_br_npc", bus.npc_f, 32'h3200);
        tick();
`ifdef DELAY_SLOT_EN
        check("pend_br_valid", {31'b0, bus.valid_d}, 32'h1);
`else
        check("pend_br_valid", {31'b0, bus.valid_d}, 32'h0);
`endif
        bus.pc_f = 32'h3200;
        settle();
        check("pend_cleared_npc", bus.npc_f, 32'h3204);

        // Pending branch overwritten by a later exception
        bus.stall     = 1'b1;
        bus.br_req    = 1'b1;
        bus.br_target = 32'h3200;
        bus.pc_f      = 32'h3204;
        bus.instr_f   = 32'h4444_4444;
        tick();
        bus.br_req  = 1'b0;
        bus.exc_req = 1'b1;
        tick();
        bus.exc_req = 1'b0;
        bus.stall   = 1'b0;
        settle();
        check("pend_exc_npc", bus.npc_f, 32'h4180);
        tick();
        check("pend_exc_valid", {31'b0, bus.valid_d}, 32'h0);
        check("pend_exc_instr", bus.instr_d, 32'h0);
        check("pend_exc_pc_d", bus.pc_d, 32'h3204);

        // Pending exception is not overwritten by a lower-priority branch
        bus.stall   = 1'b1;
        bus.exc_req = 1'b1;
        tick();
        bus.exc_req   = 1'b0;
        bus.br_req    = 1'b1;
        bus.br_target = 32'h3300;
        tick();
        bus.br_req = 1'b0;
        bus.stall  = 1'b0;
        settle();
        check("pend_keep_exc_npc", bus.npc_f, 32'h4180);
        tick();

        // Pending branch vs a new same-priority branch on release: new one wins
        bus.stall     = 1'b1;
        bus.br_req    = 1'b1;
        bus.br_target = 32'h3200;
        tick();
        bus.stall     = 1'b0;
        bus.br_target = 32'h3400;
        settle();
        check("tie_new_wins_npc", bus.npc_f, 32'h3400);
        tick();
        clear_req();

        // Simultaneous exc + eret, then eret alone
        bus.exc_req  = 1'b1;
        bus.eret_req = 1'b1;
        bus.epc      = 32'h3050;
        settle();
        check("exc_over_eret_npc", bus.npc_f, 32'h4180);
        tick();
        clear_req();
        bus.pc_f    = 32'h3050;
        bus.instr_f = 32'h5555_5555;
        tick();
        check("pre_eret_valid", {31'b0, bus.valid_d}, 32'h1);
        bus.pc_f     = 32'h3054;
        bus.eret_req = 1'b1;
        settle();
        check("eret_npc", bus.npc_f, 32'h3050);
        tick();
        clear_req();
        check("eret_valid", {31'b0, bus.valid_d}, 32'h0);
        check("eret_instr", bus.instr_d, 32'h0);
        check("eret_pc_d", bus.pc_d, 32'h3054);

        // Fetch address errors and range boundaries
        bus.instr_f = 32'h6666_6666;
        bus.pc_f    = 32'h3002;
        tick();
        check("adel_misal", {31'b0, bus.adel_d}, 32'h1);
        check("adel_misal_instr", bus.instr_d, 32'h0);
        check("adel_misal_valid", {31'b0, bus.valid_d}, 32'h1);
        check("adel_misal_pc_d", bus.pc_d, 32'h3002);
        bus.pc_f = 32'h5000;
        tick();
        check("adel_high", {31'b0, bus.adel_d}, 32'h1);
        check("adel_high_instr", bus.instr_d, 32'h0);
        bus.pc_f = 32'h2FFC;
        tick();
        check("adel_below", {31'b0, bus.adel_d}, 32'h1);
        bus.pc_f = 32'h3FFC;
        tick();
        check("adel_last_ok", {31'b0, bus.adel_d}, 32'h0);
        check("adel_last_ok_instr", bus.instr_d, 32'h6666_6666);
        bus.pc_f = 32'h4000;
        tick();
        check("adel_end", {31'b0, bus.adel_d}, 32'h1);
        bus.pc_f = 32'hFFFF_FFFC;
        settle();
        check("npc_wrap", bus.npc_f, 32'h0000_0000);

        // Reset with stall and a pending redirect: reset wins and clears pending
        bus.pc_f      = 32'h3010;
        bus.stall     = 1'b1;
        bus.br_req    = 1'b1;
        bus.br_target = 32'h3300;
        tick();
        bus.br_req = 1'b0;
        reset      = 1'b1;
        tick();
        check("rst_stall_pc_d", bus.pc_d, 32'h3000);
        check("rst_stall_valid", {31'b0, bus.valid_d}, 32'h0);
        reset     = 1'b0;
        bus.stall = 1'b0;
        bus.pc_f  = 32'h3000;
        settle();
        check("rst_clears_pend_npc", bus.npc_f, 32'h3004);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/if_redirect_stage.md
Name: if_redirect_stage

Overview:
- Fetch-side companion to the PC register. Computes the next-PC value fed into the PC register's data input, choosing between sequential, branch/jump, ERET and exception targets.
- Holds the IF/ID pipeline register that carries the fetched instruction and its PC into decode.
- Latches redirects requested while the pipeline is stalled, so that no redirect is ever lost.

Parameters:
- WIDTH, 32, datapath / address width.
- RESET_PC, 32'h0000_3000, PC value after reset; also the reset value of pc_d.
- EXC_VEC, 32'h0000_4180, exception handler entry address.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_BYTES, 32'h0000_1000, instruction memory size; legal fetch range is [IM_BASE, IM_BASE+IM_BYTES).

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- stall  in  1  hazard stall; holds the PC and IF/ID register.
- pc_f  in  WIDTH  current PC, taken from the PC register output.
- instr_f  in  32  instruction memory read data at pc_f.
- br_req  in  1  branch taken or jump, resolved in D.
- br_target  in  WIDTH  branch/jump target.
- is_jb_d  in  1  the instruction currently in D is a branch or jump (decode-supplied).
- eret_req  in  1  ERET executing.
- epc  in  WIDTH  return address for ERET.
- exc_req  in  1  exception taken.
- npc_f  out  WIDTH  next PC, driven to the PC register data input (combinational).
- instr_d  out  32  IF/ID instruction.
- pc_d  out  WIDTH  IF/ID PC.
- pc8_d  out  WIDTH  pc_d+8, the link address.
- valid_d  out  1  IF/ID entry holds a real instruction.
- adel_d  out  1  fetch address error for the D instruction.
- bd_d  out  1  the D instruction sits in a branch delay slot.

Behaviour:
- Reset, synchronous: instr_d=0, pc_d=RESET_PC, valid_d=0, adel_d=0, bd_d=0, pending register cleared (state IDLE). Reset overrides everything, including a pending redirect.
- Redirect priority, highest first: exc_req (target EXC_VEC), eret_req (target epc), br_req (target br_target).
- Pending FSM:
  - Two states, IDLE and PEND, with registers pend_kind[1:0] and pend_tgt.
  - stall=1 with any request present: capture it. IDLE->PEND. In PEND, overwrite only if the new request's priority is strictly higher.
  - stall=0 in PEND: apply the pending redirect, or a new request of equal/higher priority in the same cycle (ties go to the new request). Then go to IDLE.
  - stall=0 in IDLE: apply any current request directly.
- npc_f, combinational:
  - Applied redirect target when stall=0 and a redirect is being applied.
  - Otherwise pc_f+4, with modulo-2^WIDTH wrap.
  - While stall=1, npc_f=pc_f+4; the PC register ignores it.
- IF/ID update on clk:
  - stall=0: instr_d<=instr_f, pc_d<=pc_f, valid_d<=1.
  - stall=1: hold all IF/ID fields.
  - Flush when an applied exc or eret redirect takes effect: valid_d<=0, instr_d<=0, adel_d<=0, bd_d<=0; pc_d<=pc_f is kept for EPC use.
- Address error:
  - Condition: pc_f[1:0]!=0, or pc_f outside the legal fetch range.
  - On load, adel_d<=1, instr_d<=0 (nop), valid_d<=1.
- bd_d: on load, bd_d<=is_jb_d & valid_d.
- Latency: a redirect applied in cycle N produces pc_f=target in N+1 and the target instruction in D at N+2.
- Simultaneous reset+stall: reset wins.

Optional Feature:
- DELAY_SLOT_EN defined: a br_req redirect does not flush, so the delay-slot instruction in F enters D with bd_d=1.
- DELAY_SLOT_EN undefined:
  - An applied br_req also flushes the F instruction: the load becomes valid_d<=0, instr_d<=0.
  - bd_d is tied to 0.
- exc and eret flush in both builds.

Decomposition:
- Shared package:
  - Constants RESET_PC, EXC_VEC, IM_BASE, IM_BYTES.
  - Redirect-kind encoding REDIR_NONE=0, REDIR_BR=1, REDIR_ERET=2, REDIR_EXC=3, ordered numerically by priority.
- One sub-module, redirect_pend: the pending FSM plus the priority arbiter. It outputs the apply strobe, kind and target.

Test Plan:
- Reset at pc_f=0x3008 -> pc_d=0x3000, valid_d=0, npc_f=0x300C; after release with instr_f=0x24080001 -> instr_d=0x24080001, valid_d=1.
- br_req=1, br_target=0x3100, stall=0, pc_f=0x3010 -> npc_f=0x3100.
  - DELAY_SLOT_EN: next D has pc_d=0x3010 and bd_d=1 when is_jb_d=1.
  - No DELAY_SLOT_EN: valid_d=0.
- br_req=1 (target 0x3200) with stall=1 for 3 cycles, request dropped after cycle 1 -> npc_f=0x3200 on the first stall=0 cycle; IF/ID held throughout the stall.
- Pending br (target 0x3200), then exc_req during stall -> pending overwritten; on release npc_f=0x4180 and valid_d=0 next cycle.
- Simultaneous exc_req and eret_req (epc=0x3050) -> npc_f=0x4180. eret_req alone -> npc_f=0x3050 with flush.
- pc_f=0x3002 and pc_f=0x5000 -> adel_d=1, instr_d=0, valid_d=1. pc_f=0xFFFFFFFC -> npc_f=0x00000000 (wrap).
